// File: rtl/binop_seq_pkg.sv
// rtl/binop_seq_pkg.sv - shared state encoding and limits for the binop issue sequencer
package binop_seq_pkg;

  localparam int BINOP_SEQ_MAX_LATENCY = 15;
  localparam int BINOP_SEQ_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } binop_seq_state_t;

endpackage

// File: rtl/binop_if.sv
// rtl/binop_if.sv - operand/result bundle between the sequencer and a binary-op implementation
interface BinOp #(
  parameter int OPERAND_WIDTH = 32
);

  logic [OPERAND_WIDTH:0] lhs;
  logic [OPERAND_WIDTH:0] rhs;
  logic [OPERAND_WIDTH:0] result;

  modport Injected (output lhs, output rhs, input result);
  modport Impl     (input lhs, input rhs, output result);

endinterface

// File: rtl/binop_seq_ctrl.sv
// rtl/binop_seq_ctrl.sv - issue FSM and settle counter; BINOP_SEQ_OVERLAP_EN lets DONE accept the next request
module binop_seq_ctrl
  import binop_seq_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic resp_ready_i,
  output logic req_ready_o,
  output logic resp_valid_o,
  output logic busy_o,
  output logic load_o,
  output logic capture_o
);

  localparam logic [BINOP_SEQ_CNT_W-1:0] CNT_LOAD = BINOP_SEQ_CNT_W'(LATENCY - 1);

  binop_seq_state_t             state_q, state_d;
  logic [BINOP_SEQ_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b0;
    load_o       = 1'b0;
    capture_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          load_o  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        // Counter reaching zero marks the edge LATENCY cycles after acceptance.
        if (cnt_q == '0) begin
          capture_o = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        resp_valid_o = 1'b1;
`ifdef BINOP_SEQ_OVERLAP_EN
        req_ready_o = resp_ready_i;
        if (resp_ready_i) begin
          if (req_valid_i) begin
            load_o  = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
`else
        if (resp_ready_i) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/binop_sequencer.sv
// rtl/binop_sequencer.sv - holds operands stable into a BinOp implementation and returns its result
// BINOP_SEQ_OVERLAP_EN (in binop_seq_ctrl) overlaps response and next request.
module binop_sequencer
  import binop_seq_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int LATENCY       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPERAND_WIDTH:0] req_lhs,
  input  logic [OPERAND_WIDTH:0] req_rhs,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [OPERAND_WIDTH:0] resp_result,
  output logic                   busy,
  BinOp.Injected                 op
);

  if (LATENCY < 1 || LATENCY > BINOP_SEQ_MAX_LATENCY) begin : g_latency_range
    $error("binop_sequencer: LATENCY must be in 1..15");
  end

  logic                   load;
  logic                   capture;
  logic [OPERAND_WIDTH:0] lhs_q, lhs_d;
  logic [OPERAND_WIDTH:0] rhs_q, rhs_d;
  logic [OPERAND_WIDTH:0] result_q, result_d;

  binop_seq_ctrl #(
    .LATENCY(LATENCY)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .resp_ready_i(resp_ready),
    .req_ready_o (req_ready),
    .resp_valid_o(resp_valid),
    .busy_o      (busy),
    .load_o      (load),
    .capture_o   (capture)
  );

  always_comb begin
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    result_d = result_q;
    if (load) begin
      lhs_d = req_lhs;
      rhs_d = req_rhs;
    end
    if (capture) begin
      result_d = op.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_q    <= '0;
      rhs_q    <= '0;
      result_q <= '0;
    end else begin
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      result_q <= result_d;
    end
  end

  // Operands reach the implementation only from registers so they stay put while it settles.
  assign op.lhs      = lhs_q;
  assign op.rhs      = rhs_q;
  assign resp_result = result_q;

endmodule

// File: tb/tb_binop_sequencer.sv
// tb/tb_binop_sequencer.sv - three sequencer instances (L=1/W=32, L=3/W=32, L=1/W=7) against a timestamp model
module tb_binop_sequencer;

`ifdef BINOP_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [3];
  logic        rv    [3];
  logic        rr    [3];
  logic [32:0] lhs   [3];
  logic [32:0] rhs   [3];
  logic        rdy_w [3];
  logic        vld_w [3];
  logic        busy_w[3];
  logic [32:0] res_w [3];
  logic [32:0] opl_w [3];
  logic [32:0] opr_w [3];
  logic [32:0] res0, res1;
  logic [7:0]  res8;

  BinOp #(.OPERAND_WIDTH(32)) if1 ();
  BinOp #(.OPERAND_WIDTH(32)) if3 ();
  BinOp #(.OPERAND_WIDTH(7))  if8 ();

  // Implementations: combinational add, two-register add (settles in 3 cycles), 8-bit wrapping add.
  logic [32:0] p1, p2;
  assign if1.result = if1.lhs + if1.rhs;
  always @(posedge clk) begin
    p1 <= if3.lhs + if3.rhs;
    p2 <= p1;
  end
  assign if3.result = p2;
  assign if8.result = if8.lhs + if8.rhs;

  assign opl_w[0] = if1.lhs;
  assign opr_w[0] = if1.rhs;
  assign opl_w[1] = if3.lhs;
  assign opr_w[1] = if3.rhs;
  assign opl_w[2] = {25'b0, if8.lhs};
  assign opr_w[2] = {25'b0, if8.rhs};
  assign res_w[0] = res0;
  assign res_w[1] = res1;
  assign res_w[2] = {25'b0, res8};

  binop_sequencer #(.OPERAND_WIDTH(32), .LATENCY(1)) u0 (
    .clk(clk), .rst(rst_s[0]), .req_valid(rv[0]), .req_ready(rdy_w[0]),
    .req_lhs(lhs[0]), .req_rhs(rhs[0]), .resp_valid(vld_w[0]), .resp_ready(rr[0]),
    .resp_result(res0), .busy(busy_w[0]), .op(if1)
  );

  binop_sequencer #(.OPERAND_WIDTH(32), .LATENCY(3)) u1 (
    .clk(clk), .rst(rst_s[1]), .req_valid(rv[1]), .req_ready(rdy_w[1]),
    .req_lhs(lhs[1]), .req_rhs(rhs[1]), .resp_valid(vld_w[1]), .resp_ready(rr[1]),
    .resp_result(res1), .busy(busy_w[1]), .op(if3)
  );

  binop_sequencer #(.OPERAND_WIDTH(7), .LATENCY(1)) u2 (
    .clk(clk), .rst(rst_s[2]), .req_valid(rv[2]), .req_ready(rdy_w[2]),
    .req_lhs(lhs[2][7:0]), .req_rhs(rhs[2][7:0]), .resp_valid(vld_w[2]), .resp_ready(rr[2]),
    .resp_result(res8), .busy(busy_w[2]), .op(if8)
  );

  int passed = 0;
  int total  = 0;
  bit started = 1'b0;
  int cyc = 0;

  bit          m_inf [3];
  int          m_rdy [3];
  logic [32:0] m_pend[3];
  logic [32:0] m_res [3];
  logic [32:0] m_l   [3];
  logic [32:0] m_r   [3];

  int          mon_cyc[$];
  logic [32:0] mon_res[$];

  function automatic logic [32:0] msk(input int id, input logic [32:0] v);
    return (id == 2) ? (v & 33'hFF) : v;
  endfunction

  function automatic int lat(input int id);
    return (id == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string nm, input int id, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h, want %0h", nm, id, act, exp);
  endtask

  // Model: a request accepted at edge e yields its sum at edge e+L and stays presented until consumed.
  task automatic model_step();
    int e;
    bit pres, hs, acc;
    e = cyc + 1;
    for (int id = 0; id < 3; id++) begin
      if (rst_s[id]) begin
        m_inf[id] = 1'b0;
        m_res[id] = '0;
        m_l[id]   = '0;
        m_r[id]   = '0;
      end else begin
        pres = m_inf[id] && (cyc >= m_rdy[id]);
        hs   = pres && rr[id];
        acc  = !m_inf[id] || (OVL && hs);
        if (hs) m_inf[id] = 1'b0;
        if (acc && rv[id]) begin
          m_inf[id]  = 1'b1;
          m_rdy[id]  = e + lat(id);
          m_l[id]    = msk(id, lhs[id]);
          m_r[id]    = msk(id, rhs[id]);
          m_pend[id] = msk(id, m_l[id] + m_r[id]);
        end
        if (m_inf[id] && e == m_rdy[id]) m_res[id] = m_pend[id];
      end
    end
    cyc = e;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int id = 0; id < 3; id++) begin
        bit ev, er;
        ev = m_inf[id] && (cyc >= m_rdy[id]);
        er = !m_inf[id] || (OVL && ev && rr[id]);
        chk("resp_valid", id, vld_w[id], ev);
        chk("req_ready", id, rdy_w[id], er);
        chk("busy", id, busy_w[id], m_inf[id]);
        chk("resp_result", id, res_w[id], m_res[id]);
        chk("op_lhs", id, opl_w[id], m_l[id]);
        chk("op_rhs", id, opr_w[id], m_r[id]);
      end
      if (vld_w[0] && rr[0]) begin
        mon_cyc.push_back(cyc);
        mon_res.push_back(res_w[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hs;
    for (int id = 0; id < 3; id++) begin
      rst_s[id] = 1'b1; rv[id] = 1'b0; rr[id] = 1'b1; lhs[id] = '0; rhs[id] = '0;
    end
    tick();
    started = 1'b1;
    tick();
    for (int id = 0; id < 3; id++) rst_s[id] = 1'b0;
    chk("rst_ready", 0, rdy_w[0], 1);
    chk("rst_valid", 0, vld_w[0], 0);
    chk("rst_busy", 0, busy_w[0], 0);
    chk("rst_result", 0, res_w[0], 0);
    chk("rst_op_lhs", 1, opl_w[1], 0);

    // L=1: 5+7
    lhs[0] = 33'd5; rhs[0] = 33'd7; rv[0] = 1'b1;
    tick();
    rv[0] = 1'b0;
    chk("a_busy", 0, busy_w[0], 1);
    chk("a_valid_early", 0, vld_w[0], 0);
    chk("a_ready_busy", 0, rdy_w[0], 0);
    tick();
    chk("a_valid", 0, vld_w[0], 1);
    chk("a_result", 0, res_w[0], 33'd12);
    tick();
    chk("a_valid_after", 0, vld_w[0], 0);
    chk("a_ready_after", 0, rdy_w[0], 1);

    // L=3: 0x10+0x01, then 10 cycles of backpressure with ignored request pulses
    rr[1] = 1'b0; lhs[1] = 33'h10; rhs[1] = 33'h01; rv[1] = 1'b1;
    tick();
    rv[1] = 1'b0;
    tick();
    tick();
    chk("b_valid_early", 1, vld_w[1], 0);
    tick();
    chk("b_valid", 1, vld_w[1], 1);
    chk("b_result", 1, res_w[1], 33'h11);
    for (int i = 0; i < 10; i++) begin
      rv[1] = i[0]; lhs[1] = 33'h99;
      tick();
      chk("bp_valid", 1, vld_w[1], 1);
      chk("bp_result", 1, res_w[1], 33'h11);
    end
    rv[1] = 1'b0;
    tick();
    rr[1] = 1'b1;
    tick();
    chk("bp_release_valid", 1, vld_w[1], 0);
    chk("bp_keep_lhs", 1, opl_w[1], 33'h10);

    // L=3: reset while BUSY discards the operation
    lhs[1] = 33'd3; rhs[1] = 33'd4; rv[1] = 1'b1;
    tick();
    rv[1] = 1'b0;
    tick();
    rst_s[1] = 1'b1;
    tick();
    rst_s[1] = 1'b0;
    chk("c_valid", 1, vld_w[1], 0);
    chk("c_busy", 1, busy_w[1], 0);
    chk("c_ready", 1, rdy_w[1], 1);
    chk("c_op_lhs", 1, opl_w[1], 0);
    chk("c_op_rhs", 1, opr_w[1], 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("c_no_resp", 1, vld_w[1], 0);
    end

    // L=1: back-to-back requests with always-ready consumer
    mon_cyc.delete();
    mon_res.delete();
    for (int k = 1; k <= 3; k++) begin
      lhs[0] = 33'(k); rhs[0] = 33'(k); rv[0] = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 20 && !hs; t++) begin
        #1;
        hs = rdy_w[0];
        tick();
      end
      chk("d_accept", k, hs, 1);
    end
    rv[0] = 1'b0;
    repeat (5) tick();
    chk("d_count", 0, mon_res.size(), 3);
    for (int k = 0; k < mon_res.size() && k < 3; k++) begin
      chk("d_result", k, mon_res[k], 33'(2 * (k + 1)));
      if (k > 0) chk("d_gap", k, mon_cyc[k] - mon_cyc[k-1], OVL ? 2 : 3);
    end

    // W=7: wrapping and full-width pass-through
    lhs[2] = 33'hFF; rhs[2] = 33'h01; rv[2] = 1'b1;
    tick();
    rv[2] = 1'b0;
    tick();
    chk("e_valid", 2, vld_w[2], 1);
    chk("e_wrap", 2, res_w[2], 33'h00);
    tick();
    lhs[2] = 33'h80; rhs[2] = 33'h7F; rv[2] = 1'b1;
    tick();
    rv[2] = 1'b0;
    tick();
    chk("e_full", 2, res_w[2], 33'hFF);
    chk("e_op_lhs", 2, opl_w[2], 33'h80);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/binop_sequencer.md
# binop_sequencer

Issue stage directly upstream of any binary-operation implementation. Accepts operand pairs over a valid/ready request channel, drives them, held stable, into a `BinOp` interface through its `Injected` modport, and waits a fixed number of cycles for the implementation to settle. It then captures `result` and presents it on a valid/ready response channel. Serialises multi-cycle ALU ops so implementations stay purely combinational or fixed-latency.

## Interface
Parameters:
- `OPERAND_WIDTH`, 32: operand MSB index; all data vectors are `[OPERAND_WIDTH:0]` (OPERAND_WIDTH+1 bits); must equal the connected `BinOp` instance's parameter.
- `LATENCY`, 1: cycles the implementation needs from stable operands to valid result; legal range 1..15; elaboration error outside it.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept.
- `req_lhs`  in  OPERAND_WIDTH+1  left operand.
- `req_rhs`  in  OPERAND_WIDTH+1  right operand.
- `resp_valid`  out  1  `resp_result` valid.
- `resp_ready`  in  1  consumer accepts.
- `resp_result`  out  OPERAND_WIDTH+1  captured result.
- `busy`  out  1  high in BUSY or DONE.
- `op`  interface  `BinOp.Injected`  drives `op.lhs`/`op.rhs`, samples `op.result`.

## Operation
- States: IDLE, BUSY, DONE (3-value enum).
- IDLE: `req_ready`=1. On `req_valid`: load operand registers, load counter with LATENCY-1, go to BUSY.
- BUSY: `req_ready`=0. `op.lhs`/`op.rhs` come only from operand registers and never change here. Counter decrements each cycle. When the counter is 0, capture `op.result` into the result register and go to DONE.
- DONE: `resp_valid`=1. `resp_result` holds until the handshake. On `resp_valid && resp_ready`: go to IDLE (see Configuration for overlap).
- Operand registers keep their last value after DONE. `op` inputs change only on acceptance.
- No arithmetic in this block. Widths pass through unchanged.
- `req_valid` outside IDLE (or overlap-DONE) is ignored. Requests are never dropped, only stalled.

## Timing
- Reset values: state=IDLE, `req_ready`=1 on the first post-reset cycle, `resp_valid`=0, `resp_result`=0, `busy`=0, `op.lhs`=0, `op.rhs`=0, counter=0.
- Request accepted at edge E0: operands reach `op` after E0. Result captured at edge E0+LATENCY. `resp_valid` is high from E0+LATENCY on.
- `resp_result` equals `op.result` as sampled at edge E0+LATENCY. This requires `op.result` to be stable LATENCY cycles after the operands change.
- Without overlap, throughput is one op per LATENCY+2 cycles with an always-ready consumer.
- Backpressure: DONE holds indefinitely while `resp_ready`=0, with the result stable.
- `rst` asserted in any state: next state IDLE, and any in-flight or unconsumed result is discarded (`resp_valid`=0 next cycle). `rst` takes priority over any simultaneous handshake.

## Configuration
- `BINOP_SEQ_OVERLAP_EN` defined: in DONE, `req_ready` = `resp_ready`. A simultaneous response handshake and request handshake goes directly to BUSY with the new operands loaded. Throughput is one op per LATENCY+1 cycles. `req_ready` combinationally depends on `resp_ready` in DONE only.
- `BINOP_SEQ_OVERLAP_EN` undefined: `req_ready` is 0 in DONE, and DONE always returns to IDLE. There is no combinational path from `resp_ready` to `req_ready`.

## Structure
- Package `binop_seq_pkg` holds:
  - the `binop_seq_state_t` enum {IDLE, BUSY, DONE};
  - `BINOP_SEQ_MAX_LATENCY`=15;
  - the counter width constant (4).
- One sub-module: `binop_seq_ctrl`, the FSM plus latency counter. Its outputs are load-operands, capture-result, `req_ready`, `resp_valid` and `busy`.
- The top level holds the operand and result registers and the `op` connections.

## Test plan
- LATENCY=1, identity-add impl. Send lhs=5, rhs=7 with `resp_ready`=1 → `resp_valid` rises one cycle after acceptance with result 12, then `req_ready` returns.
- LATENCY=3, impl registers its result 3 deep. Send lhs=0x10, rhs=0x01 → result 0x11 three cycles after acceptance. `op.lhs` and `op.rhs` stay stable throughout BUSY.
- Hold `resp_ready`=0 for 10 cycles after DONE → `resp_valid` and `resp_result` hold. `req_valid` pulses are not accepted.
- Assert `rst` in BUSY (LATENCY=3, cycle 2) → next cycle IDLE, `resp_valid`=0, `op.lhs`=`op.rhs`=0, and no response ever appears.
- With `BINOP_SEQ_OVERLAP_EN`, back-to-back requests (1,1), (2,2), (3,3), LATENCY=1, always-ready consumer → results 2, 4, 6 arrive two cycles apart. Without the macro they arrive three cycles apart.
- Max-width operands: OPERAND_WIDTH=7, lhs=0xFF, rhs=0x01, impl = wrapping add → result 0x00. All 8 bits pass through unmodified.
